// File: rtl/panel_status_scheduler_pkg.sv
// Shared greenhouse display definitions: status width, panel band rows, colours and
// the panel scheduler state encoding, plus the row-to-panel band lookup.
package greenhouse_pkg;

   localparam int STATUS_W = 4;

   localparam logic [9:0] PANEL_Y1 = 10'd120;
   localparam logic [9:0] PANEL_Y2 = 10'd240;
   localparam logic [9:0] PANEL_Y3 = 10'd360;
   localparam logic [9:0] Y_LIMIT  = 10'd480;

   localparam logic [2:0] RGB_BLUE  = 3'b001;
   localparam logic [2:0] RGB_RED   = 3'b100;
   localparam logic [2:0] RGB_WHITE = 3'b111;
   localparam logic [2:0] RGB_BLACK = 3'b000;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } sched_state_e;

   // Rows at or beyond Y_LIMIT land in the last band; callers handle the blank region.
   function automatic logic [1:0] panel_band(input logic [9:0] y);
      if (y < PANEL_Y1)      return 2'd0;
      else if (y < PANEL_Y2) return 2'd1;
      else if (y < PANEL_Y3) return 2'd2;
      else                   return 2'd3;
   endfunction

endpackage

// File: rtl/panel_status_scheduler_if.sv
// Signal bundle between the status inputs / scan position and the panel scheduler.
interface panel_status_scheduler_if #(
   parameter int NUM_PANELS = 4
) ();

   logic                                          frame_start;
   logic [greenhouse_pkg::STATUS_W*NUM_PANELS-1:0] status_in;
   logic [9:0]                                    y;
   logic [1:0]                                    panel_idx;
   logic [7:0]                                    char_code;
   logic [2:0]                                    panel_rgb;
   logic [NUM_PANELS-1:0]                         alert;

   modport master (
      output frame_start, status_in, y,
      input  panel_idx, char_code, panel_rgb, alert
   );

   modport slave (
      input  frame_start, status_in, y,
      output panel_idx, char_code, panel_rgb, alert
   );

endinterface

// File: rtl/panel_status_scheduler_frame_blink_timer.sv
// Fault blink timer: counts frame_start pulses and toggles blink_on every BLINK_FRAMES
// frames. Only built when PANEL_BLINK_EN is defined.
`ifdef PANEL_BLINK_EN
module frame_blink_timer #(
   parameter int BLINK_FRAMES = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_start,
   output logic blink_on
);

   localparam int               CNT_W = $clog2(BLINK_FRAMES + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         blink_on <= 1'b0;
      end else if (frame_start) begin
         if (count == LAST) begin
            count    <= '0;
            blink_on <= ~blink_on;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule
`endif

// File: rtl/panel_status_scheduler.sv
// Frame-synchronous panel scheduler: debounces status nibbles once per frame, commits
// stable values and drives per-row glyph/colour. Fault blinking is enabled by PANEL_BLINK_EN.
module panel_status_scheduler
   import greenhouse_pkg::*;
#(
   parameter int NUM_PANELS    = 4,
   parameter int STABLE_FRAMES = 3,
   parameter int BLINK_FRAMES  = 30
) (
   input  logic                    clk,
   input  logic                    rst,
   panel_status_scheduler_if.slave bus
);

   localparam int               IDX_W      = $clog2(NUM_PANELS);
   localparam int               CNT_W      = $clog2(STABLE_FRAMES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PANELS - 1);
   localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_FRAMES);

   typedef logic [STATUS_W-1:0] nibble_t;

   sched_state_e                     state, state_next;
   logic                             load_snap, step;
   logic [IDX_W-1:0]                 idx;
   nibble_t [NUM_PANELS-1:0]         snap, cand, committed;
   logic [NUM_PANELS-1:0][CNT_W-1:0] cnt;
   logic [CNT_W-1:0]                 cnt_next;
   logic                             blink_on;
   logic [1:0]                       band;
   logic [2:0]                       alert_rgb;
   logic [1:0]                       panel_idx;
   logic [7:0]                       char_code;
   logic [2:0]                       panel_rgb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      load_snap  = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.frame_start) begin
               load_snap  = 1'b1;
               state_next = SCAN;
            end
         end
         SCAN: begin
            step = 1'b1;
            if (idx == LAST_IDX) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      if (snap[idx] != cand[idx])       cnt_next = CNT_W'(1);
      else if (cnt[idx] == STABLE_CNT)  cnt_next = STABLE_CNT;
      else                              cnt_next = cnt[idx] + 1'b1;
   end

   // NOTE: debounce state is reset too, so a reset during SCAN leaves no half-updated panel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         snap      <= '0;
         cand      <= '0;
         cnt       <= '0;
         committed <= '0;
      end else if (load_snap) begin
         snap <= bus.status_in;
         idx  <= '0;
      end else if (step) begin
         cand[idx] <= snap[idx];
         cnt[idx]  <= cnt_next;
         if (cnt_next == STABLE_CNT) committed[idx] <= snap[idx];
         idx <= idx + 1'b1;
      end
   end

   always_comb begin
      bus.alert = '0;
      for (int i = 0; i < NUM_PANELS; i++) bus.alert[i] = committed[i][STATUS_W-1];
   end

`ifdef PANEL_BLINK_EN
   frame_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
      .clk         (clk),
      .rst         (rst),
      .frame_start (bus.frame_start),
      .blink_on    (blink_on)
   );
`else
   // Without the timer a fault panel sits permanently in its "on" phase: steady red.
   assign blink_on = (BLINK_FRAMES > 0);
`endif

   always_comb begin
      band      = panel_band(bus.y);
      alert_rgb = blink_on ? RGB_RED : RGB_WHITE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         panel_idx <= 2'd0;
         char_code <= 8'd0;
         panel_rgb <= RGB_WHITE;
      end else if (bus.y >= Y_LIMIT) begin
         panel_idx <= 2'd3;
         char_code <= 8'd0;
         panel_rgb <= RGB_WHITE;
      end else begin
         panel_idx <= band;
         char_code <= {4'h0, committed[band]};
         panel_rgb <= committed[band][STATUS_W-1] ? alert_rgb : RGB_BLUE;
      end
   end

   assign bus.panel_idx = panel_idx;
   assign bus.char_code = char_code;
   assign bus.panel_rgb = panel_rgb;

endmodule

// File: tb/tb_panel_status_scheduler.sv
// Self-checking bench for panel_status_scheduler: frame-level reference model compared
// every cycle, plus directed literal expectations. Honours PANEL_BLINK_EN.
module tb_panel_status_scheduler;

   localparam int NP  = 4;
   localparam int SF  = 3;
   localparam int BF  = 2;
   localparam int GAP = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   run_checks = 1'b0;

   always #5 clk = ~clk;

   panel_status_scheduler_if #(.NUM_PANELS(NP)) bus ();

   panel_status_scheduler #(
      .NUM_PANELS    (NP),
      .STABLE_FRAMES (SF),
      .BLINK_FRAMES  (BF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: debounce evaluated per frame, commits scheduled to the cycle they land.
   logic [3:0] m_cand[NP];
   logic [3:0] m_comm[NP];
   int         m_cnt[NP];
   bit         pend_v[NP];
   int         pend_at[NP];
   logic [3:0] pend_val[NP];
   int         cyc, scan_end, m_fcount, m_y, m_p;
   bit         m_blink;
   logic [1:0] e_idx;
   logic [7:0] e_char;
   logic [2:0] e_rgb;
   logic [3:0] nib;

   function automatic void m_reset();
      for (int i = 0; i < NP; i++) begin
         m_cand[i] = '0; m_comm[i] = '0; m_cnt[i] = 0; pend_v[i] = 1'b0;
         pend_at[i] = 0; pend_val[i] = '0;
      end
      cyc = 0; scan_end = 0; m_fcount = 0; m_blink = 1'b0;
      e_idx = 2'd0; e_char = 8'd0; e_rgb = 3'b111;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_reset();
      end else begin
         m_y = int'(bus.y);
         if (m_y >= 480) begin
            e_idx = 2'd3; e_char = 8'd0; e_rgb = 3'b111;
         end else begin
            m_p    = m_y / 120;
            e_idx  = 2'(m_p);
            e_char = {4'h0, m_comm[m_p]};
`ifdef PANEL_BLINK_EN
            e_rgb  = m_comm[m_p][3] ? (m_blink ? 3'b100 : 3'b111) : 3'b001;
`else
            e_rgb  = m_comm[m_p][3] ? 3'b100 : 3'b001;
`endif
         end
         cyc++;
         for (int i = 0; i < NP; i++) begin
            if (pend_v[i] && pend_at[i] == cyc) begin
               m_comm[i] = pend_val[i];
               pend_v[i] = 1'b0;
            end
         end
         if (bus.frame_start) begin
            if (cyc > scan_end) begin
               for (int i = 0; i < NP; i++) begin
                  nib = bus.status_in[4*i +: 4];
                  if (nib == m_cand[i]) begin
                     m_cnt[i] = (m_cnt[i] + 1 > SF) ? SF : m_cnt[i] + 1;
                  end else begin
                     m_cand[i] = nib;
                     m_cnt[i]  = 1;
                  end
                  if (m_cnt[i] == SF) begin
                     pend_v[i] = 1'b1; pend_at[i] = cyc + 1 + i; pend_val[i] = nib;
                  end
               end
               scan_end = cyc + NP;
            end
            m_fcount++;
            if (m_fcount == BF) begin
               m_fcount = 0;
               m_blink  = !m_blink;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] e_alert;
      if (run_checks) begin
         for (int i = 0; i < NP; i++) e_alert[i] = m_comm[i][3];
         check("cyc panel_idx", 32'(bus.panel_idx), 32'(e_idx));
         check("cyc char_code", 32'(bus.char_code), 32'(e_char));
         check("cyc panel_rgb", 32'(bus.panel_rgb), 32'(e_rgb));
         check("cyc alert",     32'(bus.alert),     32'(e_alert));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [15:0] s);
      bus.status_in   = s;
      bus.frame_start = 1'b1;
      tick(1);
      bus.frame_start = 1'b0;
      tick(GAP);
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.status_in   = '0;
      bus.y           = 10'd50;
      tick(2);
      run_checks = 1'b1;
      check("reset panel_idx", 32'(bus.panel_idx), 32'd0);
      check("reset char_code", 32'(bus.char_code), 32'd0);
      check("reset panel_rgb", 32'(bus.panel_rgb), 32'b111);
      check("reset alert",     32'(bus.alert),     32'd0);
      rst = 1'b0;
      tick(4);
      check("idle y50 char_code", 32'(bus.char_code), 32'd0);
      check("idle y50 alert",     32'(bus.alert),     32'd0);

      // Panel 0 = 5 needs three identical frames to commit.
      frame(16'h0005);
      check("frame1 char_code", 32'(bus.char_code), 32'd0);
      frame(16'h0005);
      check("frame2 char_code", 32'(bus.char_code), 32'd0);
      frame(16'h0005);
      check("frame3 char_code", 32'(bus.char_code), 32'h05);
      check("frame3 panel_rgb", 32'(bus.panel_rgb), 32'b001);

      // Panel 1 alternating never settles.
      bus.y = 10'd150;
      frame(16'h0025);
      frame(16'h0075);
      frame(16'h0025);
      frame(16'h0075);
      check("toggle panel_idx", 32'(bus.panel_idx), 32'd1);
      check("toggle char_code", 32'(bus.char_code), 32'd0);
      check("toggle alert",     32'(bus.alert),     32'd0);

      // A pulse during SCAN must not take a second snapshot of 6.
      bus.y = 10'd50;
      bus.status_in   = 16'h0005;
      bus.frame_start = 1'b1;
      tick(1);
      bus.frame_start = 1'b0;
      tick(1);
      bus.status_in   = 16'h0006;
      bus.frame_start = 1'b1;
      tick(1);
      bus.frame_start = 1'b0;
      tick(GAP);
      frame(16'h0006);
      frame(16'h0006);
      check("ignored pulse char_code", 32'(bus.char_code), 32'h05);
      frame(16'h0006);
      check("third 6 char_code", 32'(bus.char_code), 32'h06);

      // Fault on panel 2 with blinking.
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      bus.y = 10'd300;
      frame(16'h0900);
      check("fault p1 alert", 32'(bus.alert), 32'd0);
      frame(16'h0900);
      check("fault p2 alert", 32'(bus.alert), 32'd0);
      frame(16'h0900);
      check("fault p3 alert",     32'(bus.alert),     32'b0100);
      check("fault p3 char_code", 32'(bus.char_code), 32'h09);
      check("fault p3 panel_rgb", 32'(bus.panel_rgb), 32'b100);
      frame(16'h0900);
`ifdef PANEL_BLINK_EN
      check("fault p4 panel_rgb", 32'(bus.panel_rgb), 32'b111);
`else
      check("fault p4 panel_rgb", 32'(bus.panel_rgb), 32'b100);
`endif
      frame(16'h0900);
`ifdef PANEL_BLINK_EN
      check("fault p5 panel_rgb", 32'(bus.panel_rgb), 32'b111);
`else
      check("fault p5 panel_rgb", 32'(bus.panel_rgb), 32'b100);
`endif
      frame(16'h0900);
      check("fault p6 panel_rgb", 32'(bus.panel_rgb), 32'b100);

      // Reset in the middle of SCAN.
      bus.frame_start = 1'b1;
      tick(1);
      bus.frame_start = 1'b0;
      tick(2);
      rst = 1'b1;
      #1;
      check("midscan rst panel_idx", 32'(bus.panel_idx), 32'd0);
      check("midscan rst char_code", 32'(bus.char_code), 32'd0);
      check("midscan rst panel_rgb", 32'(bus.panel_rgb), 32'b111);
      check("midscan rst alert",     32'(bus.alert),     32'd0);
      tick(1);
      rst = 1'b0;

      // Bottom band edge and the blank region below it.
      frame(16'h3000);
      frame(16'h3000);
      frame(16'h3000);
      bus.y = 10'd479;
      check("y479 before edge char_code", 32'(bus.char_code), 32'd0);
      tick(1);
      check("y479 panel_idx", 32'(bus.panel_idx), 32'd3);
      check("y479 char_code", 32'(bus.char_code), 32'h03);
      check("y479 panel_rgb", 32'(bus.panel_rgb), 32'b001);
      bus.y = 10'd480;
      check("y480 before edge char_code", 32'(bus.char_code), 32'h03);
      tick(1);
      check("y480 panel_idx", 32'(bus.panel_idx), 32'd3);
      check("y480 char_code", 32'(bus.char_code), 32'd0);
      check("y480 panel_rgb", 32'(bus.panel_rgb), 32'b111);
      tick(3);

      run_checks = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
